// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and wrap-bit pointers.
// Full and empty are decoded straight from the registered pointers.
module fifo #(
   parameter int DataWidth = 8,
   parameter int Depth     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DataWidth-1:0] i_wr_data,
   input  logic                 i_wr_en,
   input  logic                 i_rd_en,
   output logic [DataWidth-1:0] o_rd_data,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int AddrWidth = $clog2(Depth);

   logic [DataWidth-1:0] r_mem [Depth];
   logic [AddrWidth:0]   r_wr_ptr;
   logic [AddrWidth:0]   r_rd_ptr;
   logic [DataWidth-1:0] r_rd_data;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr_accept;
   logic                 w_rd_accept;
   logic [AddrWidth-1:0] w_wr_idx;
   logic [AddrWidth-1:0] w_rd_idx;

   assign w_wr_idx = r_wr_ptr[AddrWidth-1:0];
   assign w_rd_idx = r_rd_ptr[AddrWidth-1:0];

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AddrWidth] != r_rd_ptr[AddrWidth]) &&
                    (w_wr_idx == w_rd_idx);

   // A concurrent read frees the slot, so a write is still taken while full.
   assign w_rd_accept = i_rd_en & ~w_empty;
   assign w_wr_accept = i_wr_en & (~w_full | w_rd_accept);

   // Pointer and read-data registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr  <= {(AddrWidth+1){1'b0}};
         r_rd_ptr  <= {(AddrWidth+1){1'b0}};
         r_rd_data <= {DataWidth{1'b0}};
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + {{AddrWidth{1'b0}}, 1'b1};
         end
         if (w_rd_accept) begin
            r_rd_ptr  <= r_rd_ptr + {{AddrWidth{1'b0}}, 1'b1};
            r_rd_data <= r_mem[w_rd_idx];
         end
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_wr_accept) begin
         r_mem[w_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_full    = w_full;
   assign o_empty   = w_empty;

endmodule

// File: tb/tb_fifo.sv
// Directed FIFO bench: a queue model predicts acceptance, read data and flags.
module tb_fifo;

   logic       i_clk;
   logic       i_rst;
   logic [7:0] i_wr_data;
   logic       i_wr_en;
   logic       i_rd_en;
   logic [7:0] o_rd_data;
   logic       o_full;
   logic       o_empty;

   int         tests_run;
   int         tests_failed;
   logic [7:0] sb_q [$];
   logic [7:0] exp_rd;
   logic [7:0] init_words [8];

   fifo #(.DataWidth(8), .Depth(8)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_data (i_wr_data),
      .i_wr_en   (i_wr_en),
      .i_rd_en   (i_rd_en),
      .o_rd_data (o_rd_data),
      .o_full    (o_full),
      .o_empty   (o_empty)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".rd_data"}, {24'd0, o_rd_data}, {24'd0, exp_rd});
      chk({tag, ".full"}, {31'd0, o_full}, {31'd0, (sb_q.size() == 8)});
      chk({tag, ".empty"}, {31'd0, o_empty}, {31'd0, (sb_q.size() == 0)});
   endtask

   // One clock with the given requests; the model decides what the FIFO accepts.
   task automatic cyc(input string tag, input logic wr, input logic [7:0] d, input logic rd);
      logic racc;
      logic wacc;
      racc = rd && (sb_q.size() > 0);
      wacc = wr && ((sb_q.size() < 8) || racc);
      i_wr_en   = wr;
      i_wr_data = d;
      i_rd_en   = rd;
      @(posedge i_clk);
      #1;
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
      if (racc) exp_rd = sb_q.pop_front();
      if (wacc) sb_q.push_back(d);
      chk_all(tag);
   endtask

   task automatic do_reset(input string tag, input logic wr, input logic rd);
      i_rst     = 1'b1;
      i_wr_en   = wr;
      i_rd_en   = rd;
      i_wr_data = 8'hC3;
      @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      i_wr_en = 1'b0;
      i_rd_en = 1'b0;
      sb_q.delete();
      exp_rd = 8'h00;
      chk_all(tag);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_rd       = 8'h00;
      i_rst        = 1'b1;
      i_wr_en      = 1'b0;
      i_rd_en      = 1'b0;
      i_wr_data    = 8'h00;
      init_words   = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

      do_reset("reset", 1'b0, 1'b0);
      cyc("idle", 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 8; i++) cyc($sformatf("fill%0d", i), 1'b1, init_words[i], 1'b0);
      cyc("wr_full", 1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 8; i++) cyc($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1);
      cyc("rd_empty", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 8; i++) cyc($sformatf("refill%0d", i), 1'b1, init_words[i], 1'b0);
      cyc("wr_rd_full", 1'b1, 8'hAA, 1'b1);
      for (int i = 0; i < 8; i++) cyc($sformatf("drain_aa%0d", i), 1'b0, 8'h00, 1'b1);

      cyc("wr_rd_empty", 1'b1, 8'h5A, 1'b1);
      cyc("rd_5a", 1'b0, 8'h00, 1'b1);

      cyc("prewrite", 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("stream%0d", i), 1'b1, 8'(i + 1), 1'b1);
      end

      cyc("load_a", 1'b1, 8'h71, 1'b0);
      cyc("load_b", 1'b1, 8'h72, 1'b0);
      do_reset("mid_reset", 1'b1, 1'b1);
      cyc("rd_after_reset", 1'b0, 8'h00, 1'b1);
      cyc("wr_after_reset", 1'b1, 8'h3C, 1'b0);
      cyc("rd_3c", 1'b0, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
